montgomery_constant_feeder: RTL and testbench

// - Serves k and N constant blocks to montgomery_reduce via its consumed_k/consumed_N handshake.
// - Holds both constants in internal block RAM, loaded once through a config write port.
// - Hides RAM read latency with per-stream prefetch buffers.
// - Block 0 is presented after restart; block i+1 is presented the cycle after each consumed pulse.

---
 rtl/montgomery_constant_feeder_pkg.sv | 22 ++
 rtl/montgomery_constant_feeder_stream.sv | 104 ++++++++++
 rtl/montgomery_constant_feeder.sv | 79 +++++++
 tb/tb_montgomery_constant_feeder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/montgomery_constant_feeder_pkg.sv
// Shared types and default sizes for the Montgomery constant feeder.
// Build option: MONT_FEED_UNDERFLOW_CHECK_EN enables the sticky underflow flag.
package mont_feed_pkg;

  localparam int DEF_REGISTER_SIZE = 32;
  localparam int DEF_NUM_BLOCKS_K  = 128;
  localparam int DEF_NUM_BLOCKS_N  = 128;
  localparam int DEF_ROM_LATENCY   = 2;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM
  } feed_state_t;

  typedef logic [DEF_REGISTER_SIZE-1:0] block_t;

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/montgomery_constant_feeder_stream.sv
// One constant stream: block RAM, read pipeline, prefetch FIFO and FSM.
// Buffer occupancy plus reads in flight stays at LAT+1 while streaming.
module const_prefetch_stream
  import mont_feed_pkg::*;
#(
  parameter int RS  = DEF_REGISTER_SIZE,
  parameter int NB  = DEF_NUM_BLOCKS_K,
  parameter int AW  = $clog2(NB),
  parameter int LAT = DEF_ROM_LATENCY
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          restart_in,
  input  logic          consumed_in,
  input  logic          we_in,
  input  logic [AW-1:0] waddr_in,
  input  logic [RS-1:0] wdata_in,
  output logic [RS-1:0] block_out,
  output feed_state_t   state_out
);

  localparam int DEPTH = LAT + 1;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic [RS-1:0]  mem [NB];
  logic [RS-1:0]  pipe_d [LAT];
  logic [LAT-1:0] pipe_v;
  logic [RS-1:0]  fifo [DEPTH];
  logic [PW-1:0]  head, tail;
  logic [CW-1:0]  count, primed;
  logic [AW-1:0]  rd_ptr, rd_addr;
  feed_state_t    state;
  logic           pop, push, issue_prime, issue;

  function automatic logic [AW-1:0] ptr_nxt(logic [AW-1:0] p);
    return (p == AW'(NB - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] slot_nxt(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop = consumed_in && !restart_in &&
               (state == STREAM) && (count != '0);
  assign issue_prime = !restart_in && (state == PRIME) &&
                       (primed < CW'(DEPTH));
  assign issue   = restart_in || issue_prime || pop;
  assign rd_addr = restart_in ? '0 : rd_ptr;
  assign push    = pipe_v[LAT-1] && !restart_in;

  // RAM is read-first: a same-address write returns old data.
  always_ff @(posedge clk_in) begin
    if (we_in && (int'(waddr_in) < NB))
      mem[waddr_in] <= wdata_in;
    if (issue)
      pipe_d[0] <= mem[rd_addr];
    for (int i = 1; i < LAT; i++)
      pipe_d[i] <= pipe_d[i-1];
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state  <= IDLE;
      rd_ptr <= '0;
      primed <= '0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      pipe_v <= '0;
      for (int i = 0; i < DEPTH; i++)
        fifo[i] <= '0;
    end else if (restart_in) begin
      state  <= PRIME;
      rd_ptr <= ptr_nxt('0);
      primed <= CW'(1);
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      pipe_v <= LAT'(1);
      for (int i = 0; i < DEPTH; i++)
        fifo[i] <= '0;
    end else begin
      if (issue)
        rd_ptr <= ptr_nxt(rd_ptr);
      if (issue_prime)
        primed <= primed + 1'b1;
      pipe_v <= (pipe_v << 1) | LAT'(issue);
      if (push) begin
        fifo[tail] <= pipe_d[LAT-1];
        tail <= slot_nxt(tail);
      end
      if (pop)
        head <= slot_nxt(head);
      count <= count + CW'(push) - CW'(pop);
      if (state == PRIME && push && count == CW'(LAT))
        state <= STREAM;
    end
  end

  assign block_out = fifo[head];
  assign state_out = state;

endmodule

// File: rtl/montgomery_constant_feeder.sv
// Serves k and N constant blocks to the Montgomery reducer.
// Build option: MONT_FEED_UNDERFLOW_CHECK_EN enables the sticky underflow flag.
module montgomery_constant_feeder
  import mont_feed_pkg::*;
#(
  parameter int REGISTER_SIZE = DEF_REGISTER_SIZE,
  parameter int NUM_BLOCKS_K  = DEF_NUM_BLOCKS_K,
  parameter int NUM_BLOCKS_N  = DEF_NUM_BLOCKS_N,
  parameter int ROM_LATENCY   = DEF_ROM_LATENCY,
  localparam int AW = $clog2(max_int(NUM_BLOCKS_K, NUM_BLOCKS_N))
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     restart_in,
  input  logic                     consumed_k_in,
  input  logic                     consumed_N_in,
  output logic [REGISTER_SIZE-1:0] k_block_out,
  output logic [REGISTER_SIZE-1:0] N_block_out,
  output logic                     ready_out,
  input  logic                     cfg_we_in,
  input  logic                     cfg_sel_in,
  input  logic [AW-1:0]            cfg_addr_in,
  input  logic [REGISTER_SIZE-1:0] cfg_data_in,
  output logic                     underflow_out
);

  feed_state_t k_state, n_state;

  const_prefetch_stream #(
    .RS(REGISTER_SIZE), .NB(NUM_BLOCKS_K),
    .AW(AW), .LAT(ROM_LATENCY)
  ) u_k (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .restart_in  (restart_in),
    .consumed_in (consumed_k_in),
    .we_in       (cfg_we_in && !cfg_sel_in),
    .waddr_in    (cfg_addr_in),
    .wdata_in    (cfg_data_in),
    .block_out   (k_block_out),
    .state_out   (k_state)
  );

  const_prefetch_stream #(
    .RS(REGISTER_SIZE), .NB(NUM_BLOCKS_N),
    .AW(AW), .LAT(ROM_LATENCY)
  ) u_n (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .restart_in  (restart_in),
    .consumed_in (consumed_N_in),
    .we_in       (cfg_we_in && cfg_sel_in),
    .waddr_in    (cfg_addr_in),
    .wdata_in    (cfg_data_in),
    .block_out   (N_block_out),
    .state_out   (n_state)
  );

  assign ready_out = (k_state == STREAM) && (n_state == STREAM);

`ifdef MONT_FEED_UNDERFLOW_CHECK_EN
  // A streaming buffer is never empty, so not-ready covers both cases.
  logic uf_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)
      uf_q <= 1'b0;
    else if (restart_in)
      uf_q <= 1'b0;
    else if ((consumed_k_in || consumed_N_in) && !ready_out)
      uf_q <= 1'b1;
  end

  assign underflow_out = uf_q;
`else
  assign underflow_out = 1'b0;
`endif

endmodule

// File: tb/tb_montgomery_constant_feeder.sv
// Randomized bench for montgomery_constant_feeder against a
// prefetch-window reference model.
module tb_montgomery_constant_feeder;
  import mont_feed_pkg::*;

  localparam int NB    = 128;
  localparam int LAT   = 2;
  localparam int DEPTH = LAT + 1;
`ifdef MONT_FEED_UNDERFLOW_CHECK_EN
  localparam bit UF_EN = 1'b1;
`else
  localparam bit UF_EN = 1'b0;
`endif

  logic   clk_in = 1'b0;
  logic   rst_in = 1'b0;
  logic   restart_in = 1'b0;
  logic   consumed_k_in = 1'b0;
  logic   consumed_N_in = 1'b0;
  logic   cfg_we_in = 1'b0;
  logic   cfg_sel_in = 1'b0;
  logic [6:0] cfg_addr_in = '0;
  block_t cfg_data_in = '0;
  block_t k_block_out, N_block_out;
  logic   ready_out, underflow_out;

  montgomery_constant_feeder dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .restart_in    (restart_in),
    .consumed_k_in (consumed_k_in),
    .consumed_N_in (consumed_N_in),
    .k_block_out   (k_block_out),
    .N_block_out   (N_block_out),
    .ready_out     (ready_out),
    .cfg_we_in     (cfg_we_in),
    .cfg_sel_in    (cfg_sel_in),
    .cfg_addr_in   (cfg_addr_in),
    .cfg_data_in   (cfg_data_in),
    .underflow_out (underflow_out)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_err = 0;

  block_t kmem [NB];
  block_t nmem [NB];
  block_t kw[$];
  block_t nw[$];
  int     kf, nf, since;
  bit     m_primed = 1'b0;
  bit     m_uf = 1'b0;

  task automatic chk(input string tag, input block_t got, input block_t exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_ready();
    return m_primed && (since >= LAT + 2);
  endfunction

  task automatic step(input bit ck, input bit cn, input bit rs,
                      input bit we = 1'b0, input bit sel = 1'b0,
                      input int addr = 0, input block_t data = '0);
    bit rdy;
    consumed_k_in = ck;
    consumed_N_in = cn;
    restart_in    = rs;
    cfg_we_in     = we;
    cfg_sel_in    = sel;
    cfg_addr_in   = 7'(addr);
    cfg_data_in   = data;
    @(posedge clk_in);
    rdy = m_ready();
    if (rs) begin
      kw.delete();
      nw.delete();
      for (int i = 0; i < DEPTH; i++) begin
        kw.push_back(kmem[i]);
        nw.push_back(nmem[i]);
      end
      kf = DEPTH;
      nf = DEPTH;
      m_primed = 1'b1;
      since = 0;
      m_uf = 1'b0;
    end else begin
      if (ck && rdy) begin
        void'(kw.pop_front());
        kw.push_back(kmem[kf]);
        kf = (kf + 1) % NB;
      end
      if (cn && rdy) begin
        void'(nw.pop_front());
        nw.push_back(nmem[nf]);
        nf = (nf + 1) % NB;
      end
      if (UF_EN && (ck || cn) && !rdy)
        m_uf = 1'b1;
      if (since < 1000)
        since++;
    end
    if (we) begin
      if (sel) nmem[addr] = data;
      else     kmem[addr] = data;
    end
    #1;
    consumed_k_in = 1'b0;
    consumed_N_in = 1'b0;
    restart_in    = 1'b0;
    cfg_we_in     = 1'b0;
    chk("ready", 32'(ready_out), 32'(m_ready()));
    if (m_ready()) begin
      chk("k_block", k_block_out, kw[0]);
      chk("N_block", N_block_out, nw[0]);
    end
    chk("underflow", 32'(underflow_out), 32'(m_uf));
  endtask

  task automatic wait_ready();
    int lat = 0;
    while (!ready_out && lat < 20) begin
      step(1'b0, 1'b0, 1'b0);
      lat++;
    end
    chk("ready_latency", 32'(lat), 32'(LAT + 2));
  endtask

  initial begin
    #12;
    chk("rst_k", k_block_out, '0);
    chk("rst_N", N_block_out, '0);
    chk("rst_ready", 32'(ready_out), 0);
    chk("rst_uf", 32'(underflow_out), 0);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;

    for (int i = 0; i < NB; i++)
      step(0, 0, 0, 1, 0, i, 32'h1000_0000 + i);
    for (int i = 0; i < NB; i++)
      step(0, 0, 0, 1, 1, i, 32'h2000_0000 + i);

    // consume during priming, then restart clears the flag
    step(0, 0, 1);
    step(1, 0, 0);
    chk("uf_set", 32'(underflow_out), 32'(UF_EN));
    step(0, 0, 0);
    step(0, 0, 1);
    chk("uf_clear", 32'(underflow_out), 0);
    wait_ready();
    chk("k_first", k_block_out, 32'h1000_0000);
    chk("N_first", N_block_out, 32'h2000_0000);

    for (int i = 0; i < NB; i++)
      step(1, 0, 0);
    chk("k_wrap", k_block_out, 32'h1000_0000);

    for (int p = 0; p < 3 * NB; p++) begin
      int gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++)
        step(0, 0, 0);
      step(0, 1, 0);
    end
    chk("N_three_pass", N_block_out, 32'h2000_0000);

    for (int i = 0; i < 57; i++)
      step(1, 0, 0);
    chk("k_57", k_block_out, 32'h1000_0039);
    step(1, 1, 1);
    chk("ready_drop", 32'(ready_out), 0);
    wait_ready();
    chk("k_restart", k_block_out, 32'h1000_0000);
    chk("N_restart", N_block_out, 32'h2000_0000);

    // block 1 is already prefetched, block 4 is not
    step(0, 0, 0, 1, 0, 1, 32'hAAAA_0001);
    step(0, 0, 0, 1, 0, 4, 32'hBBBB_0004);
    for (int i = 0; i < 5; i++)
      step(1, 0, 0);
    step(0, 0, 1);
    wait_ready();
    step(1, 0, 0);
    chk("k_reload", k_block_out, 32'hAAAA_0001);

    for (int c = 0; c < 600; c++) begin
      bit rs = ($urandom_range(0, 99) < 2);
      bit we = m_ready() && ($urandom_range(0, 9) == 0);
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, rs,
           we, $urandom_range(0, 1) == 1, $urandom_range(0, NB - 1),
           $urandom);
    end

    step(1, 1, 0);
    #3;
    rst_in = 1'b0;
    m_primed = 1'b0;
    m_uf = 1'b0;
    #1;
    chk("async_k", k_block_out, '0);
    chk("async_N", N_block_out, '0);
    chk("async_ready", 32'(ready_out), 0);
    chk("async_uf", 32'(underflow_out), 0);
    #10;
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    step(0, 0, 1);
    wait_ready();
    chk("k_intact", k_block_out, kmem[0]);
    chk("N_intact", N_block_out, nmem[0]);
    for (int c = 0; c < 40; c++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
